jc_stack_unit: RTL and testbench

Parametrised jump-control unit for the MIPS datapath. It decides the PC mux select and jump target for the control-transfer opcodes: JMP, JV, JNV, JZ, JNZ, CALL and RET. It also handles external interrupts through a fixed vector. A DEPTH-entry return stack saves return addresses and, for interrupts, the execute-stage flags. It sits between the program-memory fetch stage and the PC mux.

---
 rtl/jc_pkg.sv | 35 +++
 rtl/jc_stack_unit_if.sv | 34 +++
 rtl/jc_ret_stack.sv | 85 ++++++++
 rtl/jc_stack_unit.sv | 153 +++++++++++++++
 tb/tb_jc_stack_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jc_pkg.sv
// jc_pkg: shared definitions for the jump-control unit.
//   - opcode constants for the control-transfer instructions
//   - FSM state enum (RUN / VECTOR)
//   - width of the non-address part of a return-stack entry
//   - helper that classifies an opcode as a control transfer
// Optional feature macro used by the unit: JC_NESTED_IRQ_EN.
package jc_pkg;

  localparam logic [5:0] OP_JMP  = 6'b011000;
  localparam logic [5:0] OP_CALL = 6'b011001;
  localparam logic [5:0] OP_JV   = 6'b011100;
  localparam logic [5:0] OP_JNV  = 6'b011101;
  localparam logic [5:0] OP_JZ   = 6'b011110;
  localparam logic [5:0] OP_JNZ  = 6'b011111;
  localparam logic [5:0] OP_RET  = 6'b010000;

  // Stack entry = {addr[AW-1:0], flags[1:0], irq}; this is the non-address part.
  localparam int ENTRY_META_W = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_VECTOR = 1'b1
  } jc_state_e;

  // True for every opcode that may redirect the PC.
  function automatic logic jc_is_ctrl(input logic [5:0] op);
    logic r;
    case (op)
      OP_JMP, OP_CALL, OP_JV, OP_JNV, OP_JZ, OP_JNZ, OP_RET: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jc_stack_unit_if.sv
// jc_stack_unit_if: bus between fetch/decode and the jump-control unit.
//   Inputs to the unit : op, jmp_address_pm, current_address, flag_ex, interrupt
//   Outputs of the unit: jmp_loc, pc_mux_sel, irq_ack, flag_restore_valid,
//                        flag_restore, in_isr, stack_ovf, stack_unf
//   master = pipeline side, slave = jc_stack_unit side.
interface jc_stack_unit_if #(
  parameter int AW = 16
);
  logic [5:0]    op;
  logic [AW-1:0] jmp_address_pm;
  logic [AW-1:0] current_address;
  logic [1:0]    flag_ex;
  logic          interrupt;
  logic [AW-1:0] jmp_loc;
  logic          pc_mux_sel;
  logic          irq_ack;
  logic          flag_restore_valid;
  logic [1:0]    flag_restore;
  logic          in_isr;
  logic          stack_ovf;
  logic          stack_unf;

  modport master (
    output op, jmp_address_pm, current_address, flag_ex, interrupt,
    input  jmp_loc, pc_mux_sel, irq_ack, flag_restore_valid, flag_restore,
           in_isr, stack_ovf, stack_unf
  );

  modport slave (
    input  op, jmp_address_pm, current_address, flag_ex, interrupt,
    output jmp_loc, pc_mux_sel, irq_ack, flag_restore_valid, flag_restore,
           in_isr, stack_ovf, stack_unf
  );
endinterface

// File: rtl/jc_ret_stack.sv
// jc_ret_stack: DEPTH-entry LIFO of return frames {addr, flags, irq}.
//   clk, reset (sync, active-low)
//   push_i + push_addr_i/push_flags_i/push_irq_i : write a frame (ignored when full)
//   pop_i                                        : drop top frame (ignored when empty)
//   full_o, empty_o                              : occupancy
//   top_addr_o/top_flags_o/top_irq_o             : current top frame
//   irq_any_o                                    : some valid frame is an interrupt frame
module jc_ret_stack
  import jc_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [1:0]    push_flags_i,
  input  logic          push_irq_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] top_addr_o,
  output logic [1:0]    top_flags_o,
  output logic          top_irq_o,
  output logic          irq_any_o
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW  = AW + ENTRY_META_W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    flags;
    logic          irq;
  } jc_entry_t;

  jc_entry_t      mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [IW-1:0]  top_idx_s;
  logic [IW-1:0]  wr_idx_s;
  jc_entry_t      top_s;
  logic           irq_any_s;

  assign full_o    = (sp_q == SPW'(DEPTH));
  assign empty_o   = (sp_q == '0);
  // When empty this index aliases a stale slot; callers only use top when not empty.
  assign top_idx_s = IW'(sp_q - SPW'(1));
  assign wr_idx_s  = IW'(sp_q);
  assign top_s     = mem_q[top_idx_s];

  assign top_addr_o  = top_s.addr;
  assign top_flags_o = top_s.flags;
  assign top_irq_o   = top_s.irq;
  assign irq_any_o   = irq_any_s;

  // OR of irq bits over the occupied slots only (slots at or above sp are stale).
  always_comb begin
    irq_any_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(sp_q)) begin
        irq_any_s = irq_any_s | mem_q[i].irq;
      end else begin
        irq_any_s = irq_any_s;
      end
    end
  end

  // Stack pointer and storage update; a reset discards every frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= jc_entry_t'({EW{1'b0}});
      end
    end else if (push_i && !pop_i && !full_o) begin
      mem_q[wr_idx_s] <= '{addr: push_addr_i, flags: push_flags_i, irq: push_irq_i};
      sp_q            <= sp_q + SPW'(1);
    end else if (pop_i && !push_i && !empty_o) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

endmodule

// File: rtl/jc_stack_unit.sv
// jc_stack_unit: jump-control unit for the MIPS datapath.
//   clk, reset (sync, active-low)
//   bus (jc_stack_unit_if.slave): decode-stage opcode/targets/flags and the
//   interrupt request in; PC mux select, jump target, interrupt/flag-restore
//   pulses, ISR status and sticky stack error flags out.
// Jump decisions are combinational on op; the RUN/VECTOR FSM inserts the
// interrupt vector cycle. Macro JC_NESTED_IRQ_EN allows interrupts while an
// interrupt frame is already on the stack.
module jc_stack_unit
  import jc_pkg::*;
#(
  parameter int            AW         = 16,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] IRQ_VECTOR = 16'hF000
) (
  input  logic            clk,
  input  logic            reset,
  jc_stack_unit_if.slave  bus
);

  jc_state_e     state_q, state_d;
  logic          irq_pend_q;
  logic          ovf_q, unf_q;

  logic          full_s, empty_s, top_irq_s, irq_any_s;
  logic [AW-1:0] top_addr_s;
  logic [1:0]    top_flags_s;

  logic          push_s, pop_s, push_irq_s;
  logic [AW-1:0] push_addr_s;
  logic [1:0]    push_flags_s;
  logic          ovf_set_s, unf_set_s;
  logic [AW-1:0] jmp_loc_s;
  logic          sel_s, ack_s, frv_s;
  logic [1:0]    fr_s;
  logic          nest_ok_s, accept_s;

  jc_ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_addr_i (push_addr_s),
    .push_flags_i(push_flags_s),
    .push_irq_i  (push_irq_s),
    .pop_i       (pop_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .top_addr_o  (top_addr_s),
    .top_flags_o (top_flags_s),
    .top_irq_o   (top_irq_s),
    .irq_any_o   (irq_any_s)
  );

`ifdef JC_NESTED_IRQ_EN
  assign nest_ok_s = 1'b1;
`else
  assign nest_ok_s = !irq_any_s;
`endif

  // A control op in the slot would be lost by the flush, so it blocks acceptance.
  assign accept_s = irq_pend_q && !jc_is_ctrl(bus.op) && !full_s && nest_ok_s;

  // Jump decode, stack requests and FSM next state.
  always_comb begin
    state_d      = state_q;
    jmp_loc_s    = bus.jmp_address_pm;
    sel_s        = 1'b0;
    ack_s        = 1'b0;
    frv_s        = 1'b0;
    fr_s         = 2'b00;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    push_addr_s  = bus.current_address;
    push_flags_s = 2'b00;
    push_irq_s   = 1'b0;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        case (bus.op)
          OP_JMP: sel_s = 1'b1;
          OP_CALL: begin
            sel_s = 1'b1;
            if (full_s) begin
              ovf_set_s = 1'b1;
            end else begin
              push_s      = 1'b1;
              push_addr_s = bus.current_address + AW'(1);
            end
          end
          OP_JV:  sel_s = bus.flag_ex[0];
          OP_JNV: sel_s = !bus.flag_ex[0];
          OP_JZ:  sel_s = bus.flag_ex[1];
          OP_JNZ: sel_s = !bus.flag_ex[1];
          OP_RET: begin
            if (empty_s) begin
              unf_set_s = 1'b1;
            end else begin
              pop_s     = 1'b1;
              sel_s     = 1'b1;
              jmp_loc_s = top_addr_s;
              frv_s     = top_irq_s;
              fr_s      = top_irq_s ? top_flags_s : 2'b00;
            end
          end
          default: sel_s = 1'b0;
        endcase
        if (accept_s) begin
          state_d = ST_VECTOR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_VECTOR: begin
        // op is ignored here; the slot's instruction is replayed after RET.
        sel_s        = 1'b1;
        jmp_loc_s    = IRQ_VECTOR;
        ack_s        = 1'b1;
        push_s       = 1'b1;
        push_addr_s  = bus.current_address;
        push_flags_s = bus.flag_ex;
        push_irq_s   = 1'b1;
        state_d      = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state, interrupt request sampling and sticky stack error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      irq_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= bus.interrupt;
      ovf_q      <= ovf_q | ovf_set_s;
      unf_q      <= unf_q | unf_set_s;
    end
  end

  assign bus.jmp_loc            = jmp_loc_s;
  assign bus.pc_mux_sel         = sel_s;
  assign bus.irq_ack            = ack_s;
  assign bus.flag_restore_valid = frv_s;
  assign bus.flag_restore       = fr_s;
  assign bus.in_isr             = irq_any_s;
  assign bus.stack_ovf          = ovf_q;
  assign bus.stack_unf          = unf_q;

endmodule

// File: tb/tb_jc_stack_unit.sv
// tb_jc_stack_unit: directed self-checking bench for jc_stack_unit
// (AW=16, DEPTH=4, IRQ_VECTOR=0xF000). Expectations for nested interrupts
// follow JC_NESTED_IRQ_EN when it is defined.
module tb_jc_stack_unit;

  localparam logic [5:0] T_NOP  = 6'b000000;
  localparam logic [5:0] T_JMP  = 6'b011000;
  localparam logic [5:0] T_CALL = 6'b011001;
  localparam logic [5:0] T_RET  = 6'b010000;

  // {op, flag_ex, expected pc_mux_sel}; flag_ex[0]=V, flag_ex[1]=Z
  localparam logic [8:0] COND_VEC [16] = '{
    {6'b011100, 2'b00, 1'b0}, {6'b011100, 2'b01, 1'b1},
    {6'b011100, 2'b10, 1'b0}, {6'b011100, 2'b11, 1'b1},
    {6'b011101, 2'b00, 1'b1}, {6'b011101, 2'b01, 1'b0},
    {6'b011101, 2'b10, 1'b1}, {6'b011101, 2'b11, 1'b0},
    {6'b011110, 2'b00, 1'b0}, {6'b011110, 2'b01, 1'b0},
    {6'b011110, 2'b10, 1'b1}, {6'b011110, 2'b11, 1'b1},
    {6'b011111, 2'b00, 1'b1}, {6'b011111, 2'b01, 1'b1},
    {6'b011111, 2'b10, 1'b0}, {6'b011111, 2'b11, 1'b0}
  };

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  jc_stack_unit_if #(.AW(16)) bus ();

  jc_stack_unit #(.AW(16), .DEPTH(4), .IRQ_VECTOR(16'hF000)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] vec;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.op = T_NOP;
    bus.jmp_address_pm  = 16'h0000;
    bus.current_address = 16'h0000;
    bus.flag_ex   = 2'b00;
    bus.interrupt = 1'b0;
    tick();
    tick();
    check_val("rst_sel", 32'(bus.pc_mux_sel), 32'd0);
    check_val("rst_ack", 32'(bus.irq_ack), 32'd0);
    check_val("rst_frv", 32'(bus.flag_restore_valid), 32'd0);
    check_val("rst_fr", 32'(bus.flag_restore), 32'd0);
    check_val("rst_isr", 32'(bus.in_isr), 32'd0);
    check_val("rst_ovf", 32'(bus.stack_ovf), 32'd0);
    check_val("rst_unf", 32'(bus.stack_unf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Conditional jumps
    bus.jmp_address_pm = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      vec = COND_VEC[i];
      bus.op      = vec[8:3];
      bus.flag_ex = vec[2:1];
      #1;
      check_val($sformatf("cond_sel_%0d", i), 32'(bus.pc_mux_sel), 32'(vec[0]));
      check_val($sformatf("cond_loc_%0d", i), 32'(bus.jmp_loc), 32'h1234);
    end
    bus.op = T_JMP;
    #1;
    check_val("jmp_sel", 32'(bus.pc_mux_sel), 32'd1);
    bus.op = T_NOP;
    #1;
    check_val("nop_sel", 32'(bus.pc_mux_sel), 32'd0);
    bus.flag_ex = 2'b00;
    tick();

    // CALL then RET
    bus.op = T_CALL;
    bus.current_address = 16'h0100;
    bus.jmp_address_pm  = 16'h0200;
    #1;
    check_val("call_sel", 32'(bus.pc_mux_sel), 32'd1);
    check_val("call_loc", 32'(bus.jmp_loc), 32'h0200);
    tick();
    bus.op = T_RET;
    bus.jmp_address_pm = 16'h5555;
    #1;
    check_val("ret_sel", 32'(bus.pc_mux_sel), 32'd1);
    check_val("ret_loc", 32'(bus.jmp_loc), 32'h0101);
    check_val("ret_frv", 32'(bus.flag_restore_valid), 32'd0);
    tick();
    bus.op = T_NOP;

    // Basic interrupt
    bus.current_address = 16'h0040;
    bus.flag_ex   = 2'b01;
    bus.interrupt = 1'b1;
    #1;
    check_val("irq_pre_ack", 32'(bus.irq_ack), 32'd0);
    tick();
    check_val("irq_e1_ack", 32'(bus.irq_ack), 32'd0);
    tick();
    check_val("irq_vec_ack", 32'(bus.irq_ack), 32'd1);
    check_val("irq_vec_sel", 32'(bus.pc_mux_sel), 32'd1);
    check_val("irq_vec_loc", 32'(bus.jmp_loc), 32'hF000);
    bus.interrupt = 1'b0;
    tick();
    check_val("irq_isr", 32'(bus.in_isr), 32'd1);
    check_val("irq_post_ack", 32'(bus.irq_ack), 32'd0);
    bus.op = T_RET;
    bus.jmp_address_pm = 16'h7777;
    #1;
    check_val("iret_loc", 32'(bus.jmp_loc), 32'h0040);
    check_val("iret_frv", 32'(bus.flag_restore_valid), 32'd1);
    check_val("iret_fr", 32'(bus.flag_restore), 32'd1);
    tick();
    bus.op = T_NOP;
    #1;
    check_val("iret_isr", 32'(bus.in_isr), 32'd0);
    check_val("iret_frv_off", 32'(bus.flag_restore_valid), 32'd0);

    // Interrupt blocked by a stream of jumps
    bus.op = T_JMP;
    bus.jmp_address_pm  = 16'h0800;
    bus.current_address = 16'h0300;
    bus.interrupt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("jblk_ack_%0d", i), 32'(bus.irq_ack), 32'd0);
    end
    bus.op = T_NOP;
    #1;
    check_val("jblk_nop_ack", 32'(bus.irq_ack), 32'd0);
    tick();
    check_val("jblk_vec_ack", 32'(bus.irq_ack), 32'd1);
    bus.interrupt = 1'b0;
    tick();
    bus.op = T_RET;
    #1;
    check_val("jblk_ret_loc", 32'(bus.jmp_loc), 32'h0300);
    tick();
    bus.op = T_NOP;

    // Overflow: five CALLs into four slots
    for (int i = 0; i < 5; i++) begin
      bus.op = T_CALL;
      bus.current_address = 16'h0010 + 16'(i);
      bus.jmp_address_pm  = 16'h0020 + 16'(i);
      #1;
      check_val($sformatf("ovf_call_sel_%0d", i), 32'(bus.pc_mux_sel), 32'd1);
      check_val($sformatf("ovf_call_loc_%0d", i), 32'(bus.jmp_loc), 32'h0020 + 32'(i));
      check_val($sformatf("ovf_pre_%0d", i), 32'(bus.stack_ovf), 32'd0);
      tick();
    end
    check_val("ovf_set", 32'(bus.stack_ovf), 32'd1);
    for (int j = 0; j < 4; j++) begin
      bus.op = T_RET;
      bus.jmp_address_pm = 16'h0900;
      #1;
      check_val($sformatf("unw_sel_%0d", j), 32'(bus.pc_mux_sel), 32'd1);
      check_val($sformatf("unw_loc_%0d", j), 32'(bus.jmp_loc), 32'h0014 - 32'(j));
      tick();
    end
    #1;
    check_val("unf_sel", 32'(bus.pc_mux_sel), 32'd0);
    check_val("unf_loc", 32'(bus.jmp_loc), 32'h0900);
    check_val("unf_pre", 32'(bus.stack_unf), 32'd0);
    tick();
    check_val("unf_set", 32'(bus.stack_unf), 32'd1);
    check_val("ovf_sticky", 32'(bus.stack_ovf), 32'd1);

    // Return address wraps
    bus.op = T_CALL;
    bus.current_address = 16'hFFFF;
    bus.jmp_address_pm  = 16'h0ABC;
    tick();
    bus.op = T_RET;
    #1;
    check_val("wrap_loc", 32'(bus.jmp_loc), 32'h0000);
    tick();
    bus.op = T_NOP;

    // Interrupt during ISR
    bus.current_address = 16'h0500;
    bus.flag_ex   = 2'b10;
    bus.interrupt = 1'b1;
    tick();
    tick();
    check_val("nst_vec1_ack", 32'(bus.irq_ack), 32'd1);
    tick();
    check_val("nst_isr", 32'(bus.in_isr), 32'd1);
    check_val("nst_run_ack", 32'(bus.irq_ack), 32'd0);
    bus.current_address = 16'h0600;
    bus.flag_ex = 2'b11;
`ifdef JC_NESTED_IRQ_EN
    tick();
    check_val("nst_vec2_ack", 32'(bus.irq_ack), 32'd1);
    bus.interrupt = 1'b0;
    tick();
    bus.op = T_RET;
    #1;
    check_val("nst_ret1_loc", 32'(bus.jmp_loc), 32'h0600);
    check_val("nst_ret1_fr", 32'(bus.flag_restore), 32'd3);
    check_val("nst_ret1_frv", 32'(bus.flag_restore_valid), 32'd1);
    tick();
    check_val("nst_mid_isr", 32'(bus.in_isr), 32'd1);
    check_val("nst_ret2_loc", 32'(bus.jmp_loc), 32'h0500);
    check_val("nst_ret2_fr", 32'(bus.flag_restore), 32'd2);
    tick();
    bus.op = T_NOP;
    #1;
    check_val("nst_end_isr", 32'(bus.in_isr), 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("nst_held_ack_%0d", i), 32'(bus.irq_ack), 32'd0);
    end
    bus.op = T_RET;
    #1;
    check_val("nst_ret_loc", 32'(bus.jmp_loc), 32'h0500);
    check_val("nst_ret_fr", 32'(bus.flag_restore), 32'd2);
    check_val("nst_ret_frv", 32'(bus.flag_restore_valid), 32'd1);
    tick();
    bus.op = T_NOP;
    #1;
    check_val("nst_after_isr", 32'(bus.in_isr), 32'd0);
    check_val("nst_after_ack", 32'(bus.irq_ack), 32'd0);
    tick();
    check_val("nst_late_ack", 32'(bus.irq_ack), 32'd1);
    bus.interrupt = 1'b0;
    tick();
    bus.op = T_RET;
    #1;
    check_val("nst_late_loc", 32'(bus.jmp_loc), 32'h0600);
    check_val("nst_late_fr", 32'(bus.flag_restore), 32'd3);
    tick();
    bus.op = T_NOP;
    #1;
    check_val("nst_end_isr", 32'(bus.in_isr), 32'd0);
`endif

    // Reset in the middle of an ISR drops the frame and sticky flags
    bus.interrupt = 1'b1;
    tick();
    tick();
    bus.interrupt = 1'b0;
    tick();
    check_val("rmid_isr_pre", 32'(bus.in_isr), 32'd1);
    rst_n = 1'b0;
    tick();
    check_val("rmid_isr", 32'(bus.in_isr), 32'd0);
    check_val("rmid_ovf", 32'(bus.stack_ovf), 32'd0);
    check_val("rmid_unf", 32'(bus.stack_unf), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
